// File: rtl/weight_loader.sv
// Packet-driven loader that routes a header-selected stream of weight words into
// per-neuron memories and tracks which neurons hold a complete weight set.
module weight_loader #(
  parameter int numWeight    = 10,
  parameter int numNeuron    = 4,
  parameter int dataWidth    = 16,
  parameter int addressWidth = $clog2(numWeight),
  parameter int neuronWidth  = $clog2(numNeuron)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  input  logic [dataWidth-1:0]    s_data,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    wen,
  output logic [neuronWidth-1:0]  w_sel,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    done,
  output logic                    err,
  output logic [numNeuron-1:0]    loaded_mask,
  output logic                    all_loaded,
  input  logic                    clr_mask
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FIN = 2'd2} state_t;

  localparam logic [addressWidth-1:0] LAST_ADDR    = addressWidth'(numWeight - 1);
  localparam logic [dataWidth-1:0]    NEURON_LIMIT = dataWidth'(numNeuron);

  state_t                  state_q, state_d;
  logic [addressWidth-1:0] cnt_q, cnt_d;
  logic [neuronWidth-1:0]  sel_q, sel_d;
  logic                    wen_q, wen_d;
  logic [addressWidth-1:0] wadd_q, wadd_d;
  logic [dataWidth-1:0]    win_q, win_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [numNeuron-1:0]    mask_q, mask_d;
  logic                    accept_s;

  assign s_ready  = (state_q != FIN);
  assign accept_s = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wen_d   = 1'b0;
    wadd_d  = wadd_q;
    win_d   = win_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        // The full header word is range-checked so stray upper bits are rejected too.
        if (accept_s) begin
          if (s_last || (s_data >= NEURON_LIMIT)) begin
            err_d = 1'b1;
          end else begin
            sel_d   = s_data[neuronWidth-1:0];
            cnt_d   = '0;
            state_d = LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          wen_d  = 1'b1;
          wadd_d = cnt_q;
          win_d  = s_data;
          if ((cnt_q == LAST_ADDR) && s_last) begin
            state_d        = FIN;
            done_d         = 1'b1;
            mask_d[sel_q]  = 1'b1;
          end else if ((cnt_q == LAST_ADDR) || s_last) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = LOAD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr_mask) begin
      mask_d = '0;
    end else begin
      mask_d = mask_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      wen_q   <= 1'b0;
      wadd_q  <= '0;
      win_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      wadd_q  <= wadd_d;
      win_q   <= win_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign wen         = wen_q;
  assign w_sel       = sel_q;
  assign wadd        = wadd_q;
  assign win         = win_q;
  assign done        = done_q;
  assign err         = err_q;
  assign loaded_mask = mask_q;
  assign all_loaded  = &mask_q;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: packet-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_weight_loader;
  localparam int NW = 10;
  localparam int NN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        wen;
  logic [1:0]  w_sel;
  logic [3:0]  wadd;
  logic [15:0] win;
  logic        done;
  logic        err;
  logic [3:0]  loaded_mask;
  logic        all_loaded;
  logic        clr_mask = 1'b0;

  weight_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .wen(wen), .w_sel(w_sel), .wadd(wadd), .win(win),
    .done(done), .err(err), .loaded_mask(loaded_mask), .all_loaded(all_loaded),
    .clr_mask(clr_mask)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int clr_pct = 0;
  bit force_clr = 1'b0;

  // Packet-level model state: whether a packet is open, its neuron, weights seen so far.
  bit        m_act = 1'b0;
  bit        m_fin = 1'b0;
  int        m_sel = 0;
  int        m_cnt = 0;
  bit [3:0]  m_mask = 4'h0;
  bit        e_wen = 1'b0;
  int        e_wadd = 0;
  int        e_win = 0;
  bit        e_done = 1'b0;
  bit        e_err = 1'b0;
  bit        nfin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task model_step();
    if (rst) begin
      m_act = 1'b0; m_fin = 1'b0; m_sel = 0; m_cnt = 0; m_mask = 4'h0;
      e_wen = 1'b0; e_wadd = 0; e_win = 0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      nfin  = 1'b0;
      e_wen = 1'b0;
      e_err = 1'b0;
      if (s_valid && !m_fin) begin
        if (!m_act) begin
          if (s_last || (int'(s_data) >= NN)) e_err = 1'b1;
          else begin m_act = 1'b1; m_sel = int'(s_data); m_cnt = 0; end
        end else begin
          e_wen = 1'b1; e_wadd = m_cnt; e_win = int'(s_data);
          if (m_cnt == NW - 1 && s_last) begin nfin = 1'b1; m_act = 1'b0; m_mask[m_sel] = 1'b1; end
          else if (m_cnt == NW - 1 || s_last) begin e_err = 1'b1; m_act = 1'b0; end
          else m_cnt = m_cnt + 1;
        end
      end
      if (clr_mask) m_mask = 4'h0;
      m_fin  = nfin;
      e_done = nfin;
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("s_ready", 32'(s_ready), 32'(!m_fin));
    chk("wen", 32'(wen), 32'(e_wen));
    chk("w_sel", 32'(w_sel), 32'(m_sel));
    chk("wadd", 32'(wadd), 32'(e_wadd));
    chk("win", 32'(win), 32'(e_win));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("loaded_mask", 32'(loaded_mask), 32'(m_mask));
    chk("all_loaded", 32'(all_loaded), 32'(m_mask == 4'hF));
  end

  task automatic cycle(input bit v, input logic [15:0] d, input bit l, input bit r);
    #1;
    s_valid  = v; s_data = d; s_last = l; rst = r;
    clr_mask = force_clr || ($urandom_range(99) < clr_pct);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // gap: 0 none, 1 alternate (one idle before each beat), 2 random idles.
  task automatic beat(input logic [15:0] d, input bit l, input int gap);
    bit taken;
    int idles;
    idles = (gap == 1) ? 1 : (gap == 2 ? int'($urandom_range(2)) : 0);
    for (int i = 0; i < idles; i++) cycle(1'b0, 16'($urandom), 1'($urandom), 1'b0);
    taken = 1'b0;
    for (int t = 0; t < 4 && !taken; t++) begin
      taken = !m_fin;
      cycle(1'b1, d, l, 1'b0);
    end
    if (!taken) chk("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1);
    #1 rst = 1'b0;
  endtask

  task automatic good_pkt(input int nrn, input int gap);
    beat(16'(nrn), 1'b0, gap);
    for (int i = 0; i < NW; i++) beat(16'($urandom), (i == NW - 1), gap);
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_mask", 32'(loaded_mask), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);

    // Header 2 then 0x1000..0x1009 back to back.
    beat(16'd2, 1'b0, 0);
    for (int i = 0; i < NW; i++) beat(16'h1000 + 16'(i), (i == NW - 1), 0);
    chk("d1_done", 32'(done), 32'd1);
    chk("d1_wadd", 32'(wadd), 32'd9);
    chk("d1_win", 32'(win), 32'h1009);
    chk("d1_sel", 32'(w_sel), 32'd2);
    chk("d1_mask", 32'(loaded_mask), 32'b0100);
    chk("d1_ready", 32'(s_ready), 32'd0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    chk("d1_done_off", 32'(done), 32'd0);

    // Neuron 1 with s_valid toggling.
    good_pkt(1, 1);
    chk("d2_mask", 32'(loaded_mask), 32'b0110);

    // Neuron 3 truncated after 6 weights.
    beat(16'd3, 1'b0, 0);
    for (int i = 0; i < 6; i++) beat(16'h3000 + 16'(i), (i == 5), 0);
    chk("d3_err", 32'(err), 32'd1);
    chk("d3_wadd", 32'(wadd), 32'd5);
    chk("d3_mask", 32'(loaded_mask), 32'b0110);

    // Out-of-range header 7, then neuron 0.
    beat(16'd7, 1'b0, 0);
    chk("d4_err", 32'(err), 32'd1);
    chk("d4_wen", 32'(wen), 32'd0);
    good_pkt(0, 0);
    chk("d4_mask", 32'(loaded_mask), 32'b0111);

    // Complete the set, then clear it.
    good_pkt(3, 0);
    chk("d5_all", 32'(all_loaded), 32'd1);
    force_clr = 1'b1;
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    force_clr = 1'b0;
    chk("d5_clr_mask", 32'(loaded_mask), 32'd0);
    chk("d5_clr_all", 32'(all_loaded), 32'd0);

    // Reset after the 4th weight, then a fresh packet.
    beat(16'd1, 1'b0, 0);
    for (int i = 0; i < 4; i++) beat(16'h4000 + 16'(i), 1'b0, 0);
    do_reset(2);
    chk("d6_wen", 32'(wen), 32'd0);
    chk("d6_wadd", 32'(wadd), 32'd0);
    chk("d6_win", 32'(win), 32'd0);
    good_pkt(1, 0);
    chk("d6_done", 32'(done), 32'd1);
    chk("d6_mask", 32'(loaded_mask), 32'b0010);

    // Randomized packets: good, short, unterminated, bad headers, clears, resets.
    clr_pct = 3;
    for (int p = 0; p < 300; p++) begin
      int kind;
      int len;
      logic [15:0] hdr;
      kind = int'($urandom_range(99));
      hdr  = ($urandom_range(9) == 0) ? 16'($urandom) : 16'($urandom_range(5));
      if ($urandom_range(99) < 2) do_reset(1);
      if (kind < 5) begin
        beat(hdr, 1'b1, 2);
      end else begin
        beat(hdr, 1'b0, 2);
        len = (kind < 70) ? NW : (kind < 85 ? int'($urandom_range(NW - 1, 1)) : NW);
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(199) == 0) do_reset(1);
          beat(16'($urandom), (kind < 85) && (i == len - 1), 2);
        end
      end
    end
    clr_pct = 0;
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
